// File: rtl/sr_ff_bank.sv
// Bank of N independent flip-flop channels, each run-time selectable as SR, JK, D or T,
// with a configurable illegal-SR policy, sticky per-channel error flags and a saturating event counter.
module sr_ff_bank #(
  parameter int             N         = 8,
  parameter int             CNT_W     = 4,
  parameter logic [N-1:0]   RESET_VAL = '0,
  parameter int             INV_POL   = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [N-1:0]     s,
  input  logic [N-1:0]     r,
  input  logic             err_clr,
  output logic [N-1:0]     q,
  output logic [N-1:0]     qb,
  output logic [N-1:0]     err,
  output logic [CNT_W-1:0] inv_cnt,
  output logic             any_err
);

  localparam logic [1:0] MODE_SR = 2'b00;
  localparam logic [1:0] MODE_JK = 2'b01;
  localparam logic [1:0] MODE_D  = 2'b10;
  localparam logic [1:0] MODE_T  = 2'b11;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [N-1:0]     q_q, q_d;
  logic [N-1:0]     qb_q, qb_d;
  logic [N-1:0]     err_q, err_d;
  logic [CNT_W-1:0] inv_cnt_q, inv_cnt_d;
  logic             any_err_q, any_err_d;
  logic [N-1:0]     inv_vec;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    q_d     = q_q;
    qb_d    = qb_q;
    inv_vec = '0;

    if (en) begin
      if (mode == MODE_SR) inv_vec = s & r;

      for (int i = 0; i < N; i++) begin
        logic qn;
        logic qb_force_lo;
        qn          = q_q[i];
        qb_force_lo = 1'b0;
        unique case (mode)
          MODE_SR: begin
            unique case ({s[i], r[i]})
              2'b10:   qn = 1'b1;
              2'b01:   qn = 1'b0;
              2'b00:   qn = q_q[i];
              default: begin
                unique case (INV_POL)
                  0:       begin qn = 1'b0; qb_force_lo = 1'b1; end
                  1:       qn = q_q[i];
                  2:       qn = 1'b1;
                  default: qn = 1'b0;
                endcase
              end
            endcase
          end
          MODE_JK: begin
            unique case ({s[i], r[i]})
              2'b10:   qn = 1'b1;
              2'b01:   qn = 1'b0;
              2'b00:   qn = q_q[i];
              default: qn = ~q_q[i];
            endcase
          end
          MODE_D:  qn = s[i];
          default: qn = s[i] ? ~q_q[i] : q_q[i];
        endcase
        q_d[i]  = qn;
        // The illegal-SR force-low breaks complementarity; toggles always derive from q.
        qb_d[i] = qb_force_lo ? 1'b0 : ~qn;
      end
    end

    // A same-edge invalid event overrides the synchronous clear for the offending channels.
    err_d = err_clr ? inv_vec : (err_q | inv_vec);

    if (err_clr) begin
      inv_cnt_d = (|inv_vec) ? CNT_ONE : '0;
    end else if ((|inv_vec) && (inv_cnt_q != CNT_MAX)) begin
      inv_cnt_d = inv_cnt_q + CNT_ONE;
    end else begin
      inv_cnt_d = inv_cnt_q;
    end

    any_err_d = |err_d;
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_q       <= RESET_VAL;
      qb_q      <= ~RESET_VAL;
      err_q     <= '0;
      inv_cnt_q <= '0;
      any_err_q <= 1'b0;
    end else begin
      q_q       <= q_d;
      qb_q      <= qb_d;
      err_q     <= err_d;
      inv_cnt_q <= inv_cnt_d;
      any_err_q <= any_err_d;
    end
  end

  assign q       = q_q;
  assign qb      = qb_q;
  assign err     = err_q;
  assign inv_cnt = inv_cnt_q;
  assign any_err = any_err_q;

endmodule

// File: tb/tb_sr_ff_bank.sv
// Self-checking bench for sr_ff_bank: four instances (one per illegal-SR policy) compared each
// cycle against a behavioural model, plus hand-computed expectations on the policy-0 instance.
module tb_sr_ff_bank;

  localparam int N     = 8;
  localparam int CNT_W = 2;
  localparam logic [N-1:0] RV = 8'hA5;
  localparam int CMAX  = 3;

  localparam logic [1:0] SR = 2'b00, JK = 2'b01, DM = 2'b10, TM = 2'b11;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic en = 1'b0;
  logic [1:0] mode = 2'b00;
  logic [N-1:0] s = '0, r = '0;
  logic err_clr = 1'b0;

  logic [N-1:0]     q_o   [4];
  logic [N-1:0]     qb_o  [4];
  logic [N-1:0]     err_o [4];
  logic [CNT_W-1:0] cnt_o [4];
  logic             any_o [4];

  int n_checks = 0;
  int n_errors = 0;
  bit started  = 1'b0;

  always #5 clk = ~clk;

  for (genvar p = 0; p < 4; p++) begin : g_dut
    sr_ff_bank #(.N(N), .CNT_W(CNT_W), .RESET_VAL(RV), .INV_POL(p)) u_dut (
      .clk(clk), .rst(rst), .en(en), .mode(mode), .s(s), .r(r), .err_clr(err_clr),
      .q(q_o[p]), .qb(qb_o[p]), .err(err_o[p]), .inv_cnt(cnt_o[p]), .any_err(any_o[p])
    );
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: per policy, per channel, next state straight from the truth tables.
  bit [N-1:0] mq [4], mqb [4], merr [4];
  int         mcnt [4];

  always @(posedge clk or posedge rst) begin
    for (int p = 0; p < 4; p++) begin
      if (rst) begin
        mq[p] = RV; mqb[p] = ~RV; merr[p] = '0; mcnt[p] = 0;
      end else begin
        bit [N-1:0] inv;
        inv = (en && mode == SR) ? (s & r) : '0;
        if (en) begin
          for (int i = 0; i < N; i++) begin
            bit cur, nq, lo;
            cur = mq[p][i]; nq = cur; lo = 0;
            case (mode)
              SR: if (s[i] && r[i]) begin
                    if (p == 0) begin nq = 0; lo = 1; end
                    else if (p == 1) nq = cur;
                    else nq = (p == 2);
                  end else if (s[i]) nq = 1;
                  else if (r[i]) nq = 0;
              JK: if (s[i] && r[i]) nq = !cur;
                  else if (s[i]) nq = 1;
                  else if (r[i]) nq = 0;
              DM: nq = s[i];
              TM: nq = cur ^ s[i];
            endcase
            mq[p][i]  = nq;
            mqb[p][i] = lo ? 1'b0 : !nq;
          end
        end
        merr[p] = err_clr ? inv : (merr[p] | inv);
        if (err_clr) mcnt[p] = (inv != 0) ? 1 : 0;
        else if (inv != 0) mcnt[p] = (mcnt[p] + 1 > CMAX) ? CMAX : mcnt[p] + 1;
      end
    end
  end

  always @(negedge clk) begin
    if (started) begin
      for (int p = 0; p < 4; p++) begin
        check($sformatf("pol%0d q", p),       q_o[p],   mq[p]);
        check($sformatf("pol%0d qb", p),      qb_o[p],  mqb[p]);
        check($sformatf("pol%0d err", p),     err_o[p], merr[p]);
        check($sformatf("pol%0d inv_cnt", p), cnt_o[p], mcnt[p]);
        check($sformatf("pol%0d any_err", p), any_o[p], |merr[p]);
      end
    end
  end

  task automatic apply(input logic e, input logic [1:0] m, input logic [N-1:0] sv,
                       input logic [N-1:0] rv, input logic c);
    @(negedge clk); #1;
    en = e; mode = m; s = sv; r = rv; err_clr = c;
    @(posedge clk); #1;
  endtask

  typedef struct { logic [1:0] m; logic [N-1:0] sv; logic [N-1:0] rv; } vec_t;
  vec_t tbl [8];

  initial begin
    #1 rst = 1'b1;
    #1 started = 1'b1;
    check("reset q", q_o[0], 8'hA5);
    check("reset qb", qb_o[0], 8'h5A);
    @(negedge clk); #1 rst = 1'b0;

    // JK toggle from q=00
    apply(1, DM, 8'h00, 8'h00, 0);
    check("d clear q", q_o[0], 8'h00);
    apply(1, JK, 8'hFF, 8'hFF, 0); check("jk t1", q_o[0], 8'hFF);
    apply(1, JK, 8'hFF, 8'hFF, 0); check("jk t2", q_o[0], 8'h00);
    apply(1, JK, 8'hFF, 8'hFF, 0); check("jk t3", q_o[0], 8'hFF);
    apply(1, JK, 8'hFF, 8'hFF, 0); check("jk t4", q_o[0], 8'h00);
    check("jk err", err_o[0], 8'h00);

    // SR set/reset then hold
    apply(1, SR, 8'h01, 8'h02, 0);
    for (int k = 0; k < 3; k++) apply(1, SR, 8'h00, 8'h00, 0);
    check("sr hold q", q_o[0], 8'h01);
    check("sr hold qb", qb_o[0], 8'hFE);

    // Illegal SR with force-low, then leave by toggle
    apply(1, SR, 8'h01, 8'h01, 0);
    check("inv q", q_o[0], 8'h00);
    check("inv qb", qb_o[0], 8'hFE);
    check("inv err", err_o[0], 8'h01);
    check("inv any", any_o[0], 1'b1);
    check("inv cnt", cnt_o[0], 2'd1);
    apply(1, TM, 8'h01, 8'h00, 0);
    check("leave q", q_o[0], 8'h01);
    check("leave qb", qb_o[0], 8'hFE);
    check("leave err", err_o[0], 8'h01);

    // Saturating counter, en=0 does not count; clear honoured while disabled
    apply(0, SR, 8'h00, 8'h00, 1);
    check("clr cnt", cnt_o[0], 2'd0);
    check("clr any", any_o[0], 1'b0);
    apply(1, SR, 8'h03, 8'h03, 0); check("sat 1", cnt_o[0], 2'd1);
    apply(1, SR, 8'h03, 8'h03, 0); check("sat 2", cnt_o[0], 2'd2);
    apply(0, SR, 8'h03, 8'h03, 0); check("sat en0", cnt_o[0], 2'd2);
    apply(1, SR, 8'h03, 8'h03, 0); check("sat 3", cnt_o[0], 2'd3);
    apply(1, SR, 8'h03, 8'h03, 0); check("sat 4", cnt_o[0], 2'd3);
    apply(1, SR, 8'h03, 8'h03, 0); check("sat 5", cnt_o[0], 2'd3);

    // Clear versus same-edge invalid event
    apply(1, SR, 8'hFF, 8'hFF, 0);
    check("err all", err_o[0], 8'hFF);
    apply(1, SR, 8'h02, 8'h02, 1);
    check("clr win err", err_o[0], 8'h02);
    check("clr win cnt", cnt_o[0], 2'd1);
    apply(1, SR, 8'h00, 8'h00, 1);
    check("clr err", err_o[0], 8'h00);
    check("clr cnt2", cnt_o[0], 2'd0);

    // Mid-cycle asynchronous reset
    apply(1, SR, 8'h10, 8'h10, 0);
    apply(1, DM, 8'h3C, 8'h00, 0);
    check("d load", q_o[0], 8'h3C);
    #2 rst = 1'b1;
    #1;
    check("async q", q_o[0], 8'hA5);
    check("async qb", qb_o[0], 8'h5A);
    check("async err", err_o[0], 8'h00);
    check("async cnt", cnt_o[0], 2'd0);
    @(negedge clk); #1 rst = 1'b0;

    // Directed mix exercising the other illegal-SR policies (checked via the model)
    tbl[0] = '{SR, 8'hF0, 8'h0F};
    tbl[1] = '{SR, 8'hCC, 8'hAA};
    tbl[2] = '{SR, 8'h00, 8'h00};
    tbl[3] = '{TM, 8'h5A, 8'h00};
    tbl[4] = '{SR, 8'hFF, 8'hFF};
    tbl[5] = '{JK, 8'h33, 8'h0F};
    tbl[6] = '{SR, 8'h81, 8'h81};
    tbl[7] = '{TM, 8'hFF, 8'h00};
    foreach (tbl[k]) apply(1, tbl[k].m, tbl[k].sv, tbl[k].rv, 0);
    apply(0, SR, 8'hFF, 8'hFF, 0);
    apply(1, DM, 8'h96, 8'h00, 1);
    @(negedge clk); #1;

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
